elastic_buffer: RTL and testbench

ELASTIC_BUFFER -- requirements
Module: elasticBuffer

---
 rtl/elastic_buffer.sv | 143 ++++++++++++++
 tb/tb_elastic_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/elastic_buffer.sv
// Elastic buffer with SKP-ordered-set clock compensation for 8b10b symbol streams.
// Optional feature: define EB_STICKY_ERR_EN to latch overflow/underflow until reset.
module elastic_buffer #(
  parameter int unsigned           DATA_WIDTH   = 10,
  parameter int unsigned           BUFFER_DEPTH = 16,
  parameter logic [DATA_WIDTH-1:0] SKP_SYMBOL   = 10'h0F4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  buffer_mode,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  skp_added,
  output logic                  skp_removed
);

  localparam int unsigned PtrW = $clog2(BUFFER_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [CntW-1:0] DepthCnt = CntW'(BUFFER_DEPTH);
  localparam logic [CntW-1:0] HighNom  = CntW'(BUFFER_DEPTH / 2 + 2);
  localparam logic [CntW-1:0] LowNom   = CntW'(BUFFER_DEPTH / 2 - 2);
  localparam logic [CntW-1:0] HighEmp  = CntW'(4);
  localparam logic [CntW-1:0] LowEmp   = CntW'(1);

  if (BUFFER_DEPTH < 8 || (BUFFER_DEPTH & (BUFFER_DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("BUFFER_DEPTH must be a power of two and at least 8");
  end

  logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  skp_added_q, skp_added_d;
  logic                  skp_removed_q, skp_removed_d;

  logic [CntW-1:0]       thr_high, thr_low;
  logic [DATA_WIDTH-1:0] head;
  logic                  head_skp, in_skp;
  logic                  rd_ok, rd_hold, rd_adv;
  logic                  skp_drop, wr_store, ovf_evt, unf_evt;

  // Both running disparities of the SKP code group are recognised.
  assign head     = mem_q[rd_ptr_q];
  assign head_skp = (head == SKP_SYMBOL) || (head == ~SKP_SYMBOL);
  assign in_skp   = (data_in == SKP_SYMBOL) || (data_in == ~SKP_SYMBOL);

  always_comb begin
    thr_high = HighNom;
    thr_low  = LowNom;
    if (buffer_mode) begin
      thr_high = HighEmp;
      thr_low  = LowEmp;
    end
  end

  always_comb begin
    rd_ok    = rd_en && (cnt_q != '0);
    unf_evt  = rd_en && (cnt_q == '0);
    rd_hold  = rd_ok && head_skp && (cnt_q <= thr_low);
    rd_adv   = rd_ok && !rd_hold;
    skp_drop = wr_en && in_skp && (cnt_q >= thr_high);
    // A full buffer still accepts a write when the same-cycle read frees a slot.
    wr_store = wr_en && !skp_drop && ((cnt_q != DepthCnt) || rd_adv);
    ovf_evt  = wr_en && !skp_drop && !wr_store;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    if (wr_store) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (rd_adv) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (rd_ok) begin
      data_out_d = head;
    end
    if (wr_store && !rd_adv) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!wr_store && rd_adv) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_comb begin
    skp_added_d   = rd_hold;
    skp_removed_d = skp_drop;
`ifdef EB_STICKY_ERR_EN
    overflow_d    = overflow_q || ovf_evt;
    underflow_d   = underflow_q || unf_evt;
`else
    overflow_d    = ovf_evt;
    underflow_d   = unf_evt;
`endif
  end

  // Storage is deliberately left unreset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_store) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      data_out_q    <= '0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      skp_added_q   <= 1'b0;
      skp_removed_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      data_out_q    <= data_out_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      skp_added_q   <= skp_added_d;
      skp_removed_q <= skp_removed_d;
    end
  end

  assign data_out    = data_out_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign skp_added   = skp_added_q;
  assign skp_removed = skp_removed_q;

endmodule

// File: tb/tb_elastic_buffer.sv
// Self-checking bench for elastic_buffer: queue-based reference model plus directed
// scenarios with hand-computed expectations, then randomized traffic.
module tb_elastic_buffer;

  localparam int DEPTH = 16;
  localparam logic [9:0] SKP = 10'h0F4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, rd_en, buffer_mode;
  logic [9:0] data_in, data_out;
  logic       overflow, underflow, skp_added, skp_removed;

  elastic_buffer #(
    .DATA_WIDTH  (10),
    .BUFFER_DEPTH(DEPTH),
    .SKP_SYMBOL  (SKP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .buffer_mode(buffer_mode),
    .data_in    (data_in),
    .data_out   (data_out),
    .overflow   (overflow),
    .underflow  (underflow),
    .skp_added  (skp_added),
    .skp_removed(skp_removed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer is a plain queue of symbols.
  logic [9:0] q[$];
  logic [9:0] exp_data = '0;
  logic       exp_ovf = 1'b0, exp_unf = 1'b0, exp_add = 1'b0, exp_rem = 1'b0;

  function automatic bit is_skp(logic [9:0] s);
    return (s == SKP) || (s == ~SKP);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    check("data_out", 32'(data_out), 32'(exp_data));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("underflow", 32'(underflow), 32'(exp_unf));
    check("skp_added", 32'(skp_added), 32'(exp_add));
    check("skp_removed", 32'(skp_removed), 32'(exp_rem));
  end

  // One clock of traffic; the model is advanced on the same rising edge as the DUT.
  task automatic step(bit wr, bit rd, bit mode, logic [9:0] d);
    int cnt, hi, lo;
    bit adv, store, ovf, unf, add, rem;
    wr_en = wr; rd_en = rd; buffer_mode = mode; data_in = d;
    @(posedge clk);
    cnt = q.size();
    hi  = mode ? 4 : DEPTH / 2 + 2;
    lo  = mode ? 1 : DEPTH / 2 - 2;
    adv = 0; store = 0; ovf = 0; unf = 0; add = 0; rem = 0;
    if (rd) begin
      if (cnt == 0) unf = 1;
      else begin
        exp_data = q[0];
        if (is_skp(q[0]) && cnt <= lo) add = 1;
        else adv = 1;
      end
    end
    if (wr) begin
      if (is_skp(d) && cnt >= hi) rem = 1;
      else if (cnt < DEPTH || adv) store = 1;
      else ovf = 1;
    end
    if (adv) void'(q.pop_front());
    if (store) q.push_back(d);
    exp_add = add;
    exp_rem = rem;
`ifdef EB_STICKY_ERR_EN
    exp_ovf = exp_ovf | ovf;
    exp_unf = exp_unf | unf;
`else
    exp_ovf = ovf;
    exp_unf = unf;
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    wr_en = 0; rd_en = 0; data_in = '0;
    #1;
    check("reset_outputs", 32'({data_out, overflow, underflow, skp_added, skp_removed}), 32'd0);
    q.delete();
    exp_data = '0; exp_ovf = 0; exp_unf = 0; exp_add = 0; exp_rem = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 0; rd_en = 0; buffer_mode = 0; data_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // In-order delivery with one-cycle read latency.
    step(1, 0, 0, 10'h0AA);
    step(1, 0, 0, 10'h2BB);
    step(1, 0, 0, 10'h1CC);
    step(0, 1, 0, '0); check("rd1", 32'(data_out), 32'h0AA);
    step(0, 1, 0, '0); check("rd2", 32'(data_out), 32'h2BB);
    step(0, 1, 0, '0); check("rd3", 32'(data_out), 32'h1CC);

    // Reset with a nonzero data_out must clear everything at once.
    step(1, 0, 0, 10'h155);
    do_reset();

    // SKP removal at the high threshold leaves occupancy at 10.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 10'(10'h100 + i));
    step(1, 0, 0, 10'h0F4); check("skp_removed_pulse", 32'(skp_removed), 32'd1);
    step(0, 0, 0, '0);      check("skp_removed_clear", 32'(skp_removed), 32'd0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, '0);
    check("last_of_ten", 32'(data_out), 32'h109);
    step(0, 1, 0, '0);      check("ten_then_empty", 32'(underflow), 32'd1);
    do_reset();

    // SKP insertion: head SKP at occupancy 6 is replayed.
    step(1, 0, 0, 10'h30B);
    for (int i = 1; i < 6; i++) step(1, 0, 0, 10'(10'h100 + i));
    step(0, 1, 0, '0); check("skp_add_data", 32'(data_out), 32'h30B);
    check("skp_add_pulse", 32'(skp_added), 32'd1);
    step(0, 1, 0, '0); check("skp_replay", 32'(data_out), 32'h30B);
    do_reset();

    // Overflow on a full buffer, then underflow on an empty one.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 10'(10'h200 + i));
    step(1, 0, 0, 10'h111); check("overflow_pulse", 32'(overflow), 32'd1);
    step(0, 0, 0, '0);
`ifdef EB_STICKY_ERR_EN
    check("overflow_sticky", 32'(overflow), 32'd1);
`else
    check("overflow_clear", 32'(overflow), 32'd0);
`endif
    step(0, 1, 0, '0); check("full_head", 32'(data_out), 32'h200);
    for (int i = 1; i < DEPTH; i++) step(0, 1, 0, '0);
    check("full_tail", 32'(data_out), 32'h20F);
    step(0, 1, 0, '0); check("underflow_pulse", 32'(underflow), 32'd1);
    check("underflow_hold", 32'(data_out), 32'h20F);
    step(0, 0, 0, '0);
`ifdef EB_STICKY_ERR_EN
    check("underflow_sticky", 32'(underflow), 32'd1);
`else
    check("underflow_clear", 32'(underflow), 32'd0);
`endif
    do_reset();

    // Randomized traffic in segments with varying write/read pressure.
    begin
      bit mode = 0;
      for (int seg = 0; seg < 40; seg++) begin
        int pw = $urandom_range(20, 80);
        int pr = $urandom_range(20, 80);
        mode = ($urandom_range(0, 2) == 0);
        for (int c = 0; c < 50; c++) begin
          int r = $urandom_range(0, 99);
          logic [9:0] d = 10'($urandom);
          if (r < 15) d = SKP;
          else if (r < 30) d = ~SKP;
          if ($urandom_range(0, 19) == 0) mode = ~mode;
          step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, mode, d);
          if ($urandom_range(0, 299) == 0) do_reset();
        end
      end
    end

    step(0, 0, 0, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
